// File: rtl/cordic_engine_param_if.sv
// cordic_engine_param_if: operand/result handshake bundle for the CORDIC engine
interface cordic_engine_param_if #(parameter int DATA_W = 16, parameter int ANGLE_W = 16);
   logic in_valid, in_ready, mode, out_valid, out_ready, sat;
   logic signed [DATA_W-1:0] x_in, y_in, res_x, res_y;
   logic [ANGLE_W-1:0] angle_in, res_angle;
   modport master (
      output in_valid, mode, x_in, y_in, angle_in, out_ready,
      input in_ready, out_valid, res_x, res_y, res_angle, sat
   );
   modport slave (
      input in_valid, mode, x_in, y_in, angle_in, out_ready,
      output in_ready, out_valid, res_x, res_y, res_angle, sat
   );
endinterface

// File: rtl/cordic_engine_param.sv
// cordic_engine_param: iterative rotation/vectoring CORDIC, one micro-rotation per clock
module cordic_engine_param #(
   parameter int DATA_W = 16,
   parameter int ANGLE_W = 16,
   parameter int ITER = 16
) (
   input logic clk,
   input logic rst,
   cordic_engine_param_if.slave io
);
   localparam int XW = DATA_W + 2;
   localparam int IW = $clog2(ITER);
   localparam logic signed [XW+17:0] K = (XW+18)'(39797);
   localparam logic signed [XW+17:0] RND = (XW+18)'(32768);
   localparam logic signed [XW+1:0] VMAX = (XW+2)'((1 <<< (DATA_W-1)) - 1);
   localparam logic signed [XW+1:0] VMIN = (XW+2)'(-(1 <<< (DATA_W-1)));
   typedef enum logic [1:0] {IDLE, CALC, SCALE, DONE} state_t;
   state_t state;
   logic md;
   logic [IW-1:0] iter;
   logic signed [XW-1:0] x, y, xe, ye, x0, y0, xs, ys;
   logic [ANGLE_W-1:0] z, z0;
   logic [1:0] q;
   logic xn, dir;
   logic signed [XW+1:0] sx, sy;
   logic [ANGLE_W-1:0] atan_tab [ITER];
   function automatic logic [ANGLE_W-1:0] atan_val(input int i);
      return ANGLE_W'($rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** ANGLE_W) / (2.0 * 3.141592653589793) + 0.5));
   endfunction
   function automatic logic signed [XW+1:0] scale(input logic signed [XW-1:0] v);
      logic signed [XW+17:0] p;
      p = v * K + RND;
      return p[XW+17:16];
   endfunction
   function automatic logic [DATA_W-1:0] clamp(input logic signed [XW+1:0] s);
      return s > VMAX ? VMAX[DATA_W-1:0] : s < VMIN ? VMIN[DATA_W-1:0] : s[DATA_W-1:0];
   endfunction
   for (genvar i = 0; i < ITER; i++) begin : g_tab
      assign atan_tab[i] = atan_val(i);
   end
   // quadrant pre-rotation keeps the residual angle inside the CORDIC convergence range
   always_comb begin
      xe = XW'(io.x_in);
      ye = XW'(io.y_in);
      xn = io.x_in[DATA_W-1];
      q = io.angle_in[ANGLE_W-1 -: 2];
      x0 = io.mode ? (xn ? -xe : xe) : q == 2'd0 ? xe : q == 2'd1 ? -ye : q == 2'd2 ? -xe : ye;
      y0 = io.mode ? (xn ? -ye : ye) : q == 2'd0 ? ye : q == 2'd1 ? xe : q == 2'd2 ? -ye : -xe;
      z0 = io.mode ? (xn ? {1'b1, {(ANGLE_W-1){1'b0}}} : '0) : {2'b00, io.angle_in[ANGLE_W-3:0]};
      xs = x >>> iter;
      ys = y >>> iter;
      dir = md ? y[XW-1] : ~z[ANGLE_W-1];
      sx = scale(x);
      sy = scale(y);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         io.in_ready <= 1'b1;
         io.out_valid <= 1'b0;
         io.sat <= 1'b0;
         io.res_x <= '0;
         io.res_y <= '0;
         io.res_angle <= '0;
         md <= 1'b0;
         iter <= '0;
         x <= '0;
         y <= '0;
         z <= '0;
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               md <= io.mode;
               x <= x0;
               y <= y0;
               z <= z0;
               iter <= '0;
               io.in_ready <= 1'b0;
               state <= CALC;
            end
            CALC: begin
               x <= dir ? x - ys : x + ys;
               y <= dir ? y + xs : y - xs;
               z <= dir ? z - atan_tab[iter] : z + atan_tab[iter];
               iter <= iter + 1'b1;
               if (iter == IW'(ITER-1)) state <= SCALE;
            end
            SCALE: begin
               io.res_x <= clamp(sx);
               io.res_y <= clamp(sy);
               io.sat <= (sx > VMAX) | (sx < VMIN) | (sy > VMAX) | (sy < VMIN);
               io.res_angle <= md ? z : '0;
               io.out_valid <= 1'b1;
               state <= DONE;
            end
            DONE: if (io.out_ready) begin
               io.out_valid <= 1'b0;
               io.in_ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
